graph_search_sched: RTL
=======================

Name: graph_search_sched

Overview:
- Scheduler and controller in front of the graph path-search engine; the engine does the level-by-level forward/backward edge scan.
- Accepts shortest-path requests (start node, end node, level limit) from NUM_REQ requesters and arbitrates round-robin.
- Validates each request, configures and launches the engine, waits for completion, and returns one tagged response per request.
- Only one search is in flight at a time.

Parameters:
- NUM_REQ, 4, number of requester channels.
- NODE_W, 7, node index width.
- NUM_NODES, 65, valid node indices are 0..NUM_NODES-1.
- LEVEL_W, 4, level/hop-count width.
- MAX_LEVEL_DEF, 10, level limit applied when a request's req_max_lvl is 0.
- TIMEOUT_CYC, 16384, WAIT-state cycle budget (used only with the optional feature).

Ports:
- CLK  in  1  clock; all logic on posedge.
- RST  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  one-hot accept; high only for the granted requester.
- req_start  in  NUM_REQ*NODE_W  start node, flattened; slot i at [i*NODE_W +: NODE_W].
- req_end  in  NUM_REQ*NODE_W  end node, flattened.
- req_max_lvl  in  NUM_REQ*LEVEL_W  level limit; 0 means use MAX_LEVEL_DEF.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  clog2(NUM_REQ)  index of the requester being answered.
- rsp_status  out  2  00 FOUND, 01 NOT_FOUND, 10 RANGE_ERR, 11 TIMEOUT.
- rsp_level  out  LEVEL_W  path length in levels; 0 unless status is FOUND.
- eng_start  out  1  one-cycle launch pulse to the engine.
- eng_start_pt, eng_end_pt  out  NODE_W  engine configuration.
- eng_max_lvl  out  LEVEL_W  engine level limit.
- eng_abort  out  1  one-cycle abort pulse to the engine.
- eng_done  in  1  engine finished; path found.
- eng_fail  in  1  engine hit the level limit without reaching the end node.
- eng_level  in  LEVEL_W  found path length, valid when eng_done is high.

Behaviour:
- Reset values:
  - state IDLE; round-robin pointer 0.
  - All outputs 0, including req_ready, rsp_valid, eng_start and eng_abort.
  - eng_* configuration registers 0.
- States: IDLE, CHECK, LAUNCH, WAIT, RESP.
- IDLE:
  - If any req_valid is set, grant the first set bit at or after the pointer, wrapping.
  - req_ready[grant] is combinational and asserted in that same cycle.
  - On that clock edge: capture start, end, limit and id; set pointer to grant+1 mod NUM_REQ; go to CHECK.
  - No grant when all req_valid are 0.
- CHECK (one cycle):
  - If start ≥ NUM_NODES or end ≥ NUM_NODES → status RANGE_ERR, go to RESP.
  - Else if start == end → status FOUND, level 0, go to RESP.
  - Else → LAUNCH.
  - The engine is never started for RANGE_ERR or start == end requests.
- LAUNCH:
  - eng_start = 1 for exactly one cycle, then go to WAIT.
  - eng_start_pt, eng_end_pt and eng_max_lvl are registered on entry to LAUNCH and held stable through WAIT.
- WAIT:
  - eng_done → FOUND, rsp_level = eng_level, go to RESP.
  - eng_fail → NOT_FOUND, go to RESP.
  - eng_done and eng_fail in the same cycle → eng_done wins.
- RESP:
  - rsp_valid held high with id, status and level stable until rsp_ready is sampled high, then go to IDLE.
  - Latency from acceptance to rsp_valid: 2 cycles for RANGE_ERR and start == end; 3 + engine cycles otherwise.
- Back-to-back: a new grant is possible in the IDLE cycle immediately after the rsp handshake.
- Fairness: a requester holding req_valid high is granted within NUM_REQ requests.
- Reset asserted mid-search:
  - Return to IDLE, drop rsp_valid, emit no eng_abort.
  - The engine shares RST and is reset by it.
- eng_done or eng_fail outside WAIT is ignored.

Optional Feature:
- GRAPH_SCHED_TIMEOUT_EN defined:
  - A 15-bit cycle counter clears on entry to WAIT.
  - If it reaches TIMEOUT_CYC-1 with no eng_done/eng_fail: pulse eng_abort for 1 cycle, set status TIMEOUT, go to RESP.
  - eng_done or eng_fail in that same cycle takes priority over the timeout.
- Undefined:
  - No counter; eng_abort is tied to 0; WAIT waits indefinitely.

Decomposition:
- Shared package graph_pkg holds:
  - NODE_W, LEVEL_W, NUM_NODES;
  - the rsp_status encoding enum;
  - the scheduler state enum.
- Sub-module graph_rr_arbiter:
  - parametric NUM_REQ round-robin arbiter: request vector plus pointer in, one-hot grant and index out.
  - Reusable for future multi-engine sharing.

Test Plan:
- req_valid=0001, start 3, end 40, limit 0; engine returns eng_done with eng_level 5 → eng_max_lvl=10; rsp id0 FOUND level 5.
- req_valid=1111 held continuously, each answered immediately → grant order 0,1,2,3,0; req_ready one-hot on every accept.
- req start 70 → rsp RANGE_ERR two cycles after accept, eng_start never pulses.
- req start 12, end 12 → rsp FOUND level 0, engine idle.
- eng_fail after launch → NOT_FOUND, level 0; with eng_done and eng_fail asserted together → FOUND.
- With GRAPH_SCHED_TIMEOUT_EN, TIMEOUT_CYC=100 and the engine silent → eng_abort pulses once and rsp TIMEOUT; without the macro no response, then RST mid-WAIT → IDLE and all outputs 0.

Source files
------------

// File: rtl/graph_pkg.sv
// Shared constants, encodings and helpers for the graph path-search scheduler.
package graph_pkg;

    localparam int unsigned NODE_W    = 7;
    localparam int unsigned LEVEL_W   = 4;
    localparam int unsigned NUM_NODES = 65;

    // Response status encoding
    typedef enum logic [1:0] {
        RSP_FOUND     = 2'b00,
        RSP_NOT_FOUND = 2'b01,
        RSP_RANGE_ERR = 2'b10,
        RSP_TIMEOUT   = 2'b11
    } rsp_status_e;

    // Scheduler states
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_LAUNCH = 3'd2,
        S_WAIT   = 3'd3,
        S_RESP   = 3'd4
    } sched_state_e;

    // True when a node index addresses an existing node
    function automatic logic node_ok(input logic [NODE_W-1:0] n);
        return (32'(n) < NUM_NODES);
    endfunction

    // A zero level limit selects the default limit
    function automatic logic [LEVEL_W-1:0] eff_limit(input logic [LEVEL_W-1:0] lim,
                                                     input logic [LEVEL_W-1:0] def);
        return (lim == '0) ? def : lim;
    endfunction

endpackage

// File: rtl/graph_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr_i, wrapping.
module graph_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    logic [IDX_W-1:0] slot;

    // Scan from the pointer and take the first set request
    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        slot    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            slot = IDX_W'((32'(ptr_i) + i) % NUM_REQ);
            if (!valid_o && req_i[slot]) begin
                valid_o     = 1'b1;
                gnt_o[slot] = 1'b1;
                idx_o       = slot;
            end
        end
    end

endmodule

// File: rtl/graph_search_sched.sv
// Scheduler in front of the graph path-search engine: arbitrates requests,
// validates them, runs one engine search at a time and returns a tagged response.
// Optional WAIT timeout with engine abort: define GRAPH_SCHED_TIMEOUT_EN.
module graph_search_sched
    import graph_pkg::*;
#(
    parameter int unsigned NUM_REQ       = 4,
    parameter int unsigned MAX_LEVEL_DEF = 10,
    parameter int unsigned TIMEOUT_CYC   = 16384
) (
    input  logic                         CLK,
    input  logic                         RST,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*NODE_W-1:0]    req_start,
    input  logic [NUM_REQ*NODE_W-1:0]    req_end,
    input  logic [NUM_REQ*LEVEL_W-1:0]   req_max_lvl,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0]   rsp_id,
    output logic [1:0]                   rsp_status,
    output logic [LEVEL_W-1:0]           rsp_level,
    output logic                         eng_start,
    output logic [NODE_W-1:0]            eng_start_pt,
    output logic [NODE_W-1:0]            eng_end_pt,
    output logic [LEVEL_W-1:0]           eng_max_lvl,
    output logic                         eng_abort,
    input  logic                         eng_done,
    input  logic                         eng_fail,
    input  logic [LEVEL_W-1:0]           eng_level
);

    localparam int unsigned ID_W = $clog2(NUM_REQ);
    localparam logic [LEVEL_W-1:0] LVL_DEF = LEVEL_W'(MAX_LEVEL_DEF);

    // Parameter sanity: pointer needs >=2 requesters, timeout must fit the 15-bit counter
    if (NUM_REQ < 2 || TIMEOUT_CYC < 2 || TIMEOUT_CYC > 32768) begin : g_bad_param
        $error("graph_search_sched: NUM_REQ or TIMEOUT_CYC out of range");
    end

    sched_state_e        state_q, state_d;
    logic [ID_W-1:0]     ptr_q, ptr_d;
    logic [ID_W-1:0]     id_q, id_d;
    logic [NODE_W-1:0]   start_q, start_d;
    logic [NODE_W-1:0]   end_q, end_d;
    logic [LEVEL_W-1:0]  lim_q, lim_d;
    logic                eng_start_q, eng_start_d;
    logic [NODE_W-1:0]   eng_start_pt_q, eng_start_pt_d;
    logic [NODE_W-1:0]   eng_end_pt_q, eng_end_pt_d;
    logic [LEVEL_W-1:0]  eng_max_lvl_q, eng_max_lvl_d;
    logic                rsp_valid_q, rsp_valid_d;
    rsp_status_e         rsp_status_q, rsp_status_d;
    logic [LEVEL_W-1:0]  rsp_level_q, rsp_level_d;

`ifdef GRAPH_SCHED_TIMEOUT_EN
    localparam logic [14:0] TMO_LAST = 15'(TIMEOUT_CYC - 1);
    logic [14:0]         tmo_cnt_q, tmo_cnt_d;
    logic                eng_abort_q, eng_abort_d;
`endif

    logic [NUM_REQ-1:0]  arb_gnt;
    logic [ID_W-1:0]     arb_idx;
    logic                arb_any;
    logic [NODE_W-1:0]   sel_start;
    logic [NODE_W-1:0]   sel_end;
    logic [LEVEL_W-1:0]  sel_lim;

    graph_rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .gnt_o   (arb_gnt),
        .idx_o   (arb_idx),
        .valid_o (arb_any)
    );

    // Mux out the granted requester's payload
    always_comb begin
        sel_start = '0;
        sel_end   = '0;
        sel_lim   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (arb_idx == ID_W'(i)) begin
                sel_start = req_start[i*NODE_W +: NODE_W];
                sel_end   = req_end[i*NODE_W +: NODE_W];
                sel_lim   = req_max_lvl[i*LEVEL_W +: LEVEL_W];
            end
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        id_d           = id_q;
        start_d        = start_q;
        end_d          = end_q;
        lim_d          = lim_q;
        eng_start_d    = 1'b0;
        eng_start_pt_d = eng_start_pt_q;
        eng_end_pt_d   = eng_end_pt_q;
        eng_max_lvl_d  = eng_max_lvl_q;
        rsp_valid_d    = rsp_valid_q;
        rsp_status_d   = rsp_status_q;
        rsp_level_d    = rsp_level_q;
        req_ready      = '0;
`ifdef GRAPH_SCHED_TIMEOUT_EN
        tmo_cnt_d      = tmo_cnt_q;
        eng_abort_d    = 1'b0;
`endif
        unique case (state_q)
            S_IDLE: begin
                req_ready = arb_gnt;
                if (arb_any) begin
                    id_d    = arb_idx;
                    start_d = sel_start;
                    end_d   = sel_end;
                    lim_d   = sel_lim;
                    ptr_d   = (arb_idx == ID_W'(NUM_REQ - 1)) ? '0 : ID_W'(arb_idx + 1'b1);
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (!node_ok(start_q) || !node_ok(end_q)) begin
                    rsp_status_d = RSP_RANGE_ERR;
                    rsp_level_d  = '0;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end else if (start_q == end_q) begin
                    rsp_status_d = RSP_FOUND;
                    rsp_level_d  = '0;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    eng_start_pt_d = start_q;
                    eng_end_pt_d   = end_q;
                    eng_max_lvl_d  = eff_limit(lim_q, LVL_DEF);
                    eng_start_d    = 1'b1;
                    state_d        = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
`ifdef GRAPH_SCHED_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
                state_d = S_WAIT;
            end
            S_WAIT: begin
`ifdef GRAPH_SCHED_TIMEOUT_EN
                tmo_cnt_d = tmo_cnt_q + 15'd1;
`endif
                if (eng_done) begin
                    rsp_status_d = RSP_FOUND;
                    rsp_level_d  = eng_level;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end else if (eng_fail) begin
                    rsp_status_d = RSP_NOT_FOUND;
                    rsp_level_d  = '0;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end
`ifdef GRAPH_SCHED_TIMEOUT_EN
                else if (tmo_cnt_q == TMO_LAST) begin
                    eng_abort_d  = 1'b1;
                    rsp_status_d = RSP_TIMEOUT;
                    rsp_level_d  = '0;
                    rsp_valid_d  = 1'b1;
                    state_d      = S_RESP;
                end
`endif
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q        <= S_IDLE;
            ptr_q          <= '0;
            id_q           <= '0;
            start_q        <= '0;
            end_q          <= '0;
            lim_q          <= '0;
            eng_start_q    <= 1'b0;
            eng_start_pt_q <= '0;
            eng_end_pt_q   <= '0;
            eng_max_lvl_q  <= '0;
            rsp_valid_q    <= 1'b0;
            rsp_status_q   <= RSP_FOUND;
            rsp_level_q    <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            id_q           <= id_d;
            start_q        <= start_d;
            end_q          <= end_d;
            lim_q          <= lim_d;
            eng_start_q    <= eng_start_d;
            eng_start_pt_q <= eng_start_pt_d;
            eng_end_pt_q   <= eng_end_pt_d;
            eng_max_lvl_q  <= eng_max_lvl_d;
            rsp_valid_q    <= rsp_valid_d;
            rsp_status_q   <= rsp_status_d;
            rsp_level_q    <= rsp_level_d;
        end
    end

`ifdef GRAPH_SCHED_TIMEOUT_EN
    // WAIT cycle counter and abort pulse
    always_ff @(posedge CLK) begin
        if (RST) begin
            tmo_cnt_q   <= '0;
            eng_abort_q <= 1'b0;
        end else begin
            tmo_cnt_q   <= tmo_cnt_d;
            eng_abort_q <= eng_abort_d;
        end
    end

    assign eng_abort = eng_abort_q;
`else
    assign eng_abort = 1'b0;
`endif

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = id_q;
    assign rsp_status   = rsp_status_q;
    assign rsp_level    = rsp_level_q;
    assign eng_start    = eng_start_q;
    assign eng_start_pt = eng_start_pt_q;
    assign eng_end_pt   = eng_end_pt_q;
    assign eng_max_lvl  = eng_max_lvl_q;

endmodule
